// File: rtl/spi_pkg.sv
// Shared definitions for the SPI RAM command controller: command codes,
// controller states and default geometry.
package spi_pkg;

   localparam int DEF_MEM_DEPTH = 256;
   localparam int DEF_ADDR_SIZE = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      TX_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/spi_cmd_decode.sv
// Splits a received SPI word into command and payload and flags whether
// the payload is a legal RAM address.
module spi_cmd_decode
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
   input  logic [ADDR_SIZE+1:0] rx_data,
   output logic [1:0]           cmd,
   output logic [ADDR_SIZE-1:0] payload,
   output logic                 in_range
);

   // Extra top bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
   localparam logic [ADDR_SIZE:0] DEPTH_L = MEM_DEPTH[ADDR_SIZE:0];

   // Pure field split plus the address range check.
   always_comb begin
      cmd      = rx_data[ADDR_SIZE+1:ADDR_SIZE];
      payload  = rx_data[ADDR_SIZE-1:0];
      in_range = ({1'b0, rx_data[ADDR_SIZE-1:0]} < DEPTH_L);
   end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command controller between the SPI slave and a single-port synchronous
// RAM: decodes commands, issues RAM strobes and returns read data.
module spi_ram_ctrl
   import spi_pkg::*;
#(
   parameter int MEM_DEPTH = DEF_MEM_DEPTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int RD_LAT    = 1,
   parameter int AUTO_INC  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_SIZE+1:0] rx_data,
   input  logic                 rx_valid,
   output logic [ADDR_SIZE-1:0] tx_data,
   output logic                 tx_valid,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [ADDR_SIZE-1:0] mem_wdata,
   input  logic [ADDR_SIZE-1:0] mem_rdata,
   output logic                 busy,
   output logic                 cmd_err
);

   localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
   localparam logic [1:0]           LAT_L     = 2'(RD_LAT);

   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic                   wr_addr_vld_q, wr_addr_vld_d, rd_addr_vld_q, rd_addr_vld_d;
   logic [ADDR_SIZE-1:0]   tx_data_d, mem_addr_d, mem_wdata_d;
   logic                   tx_valid_d, mem_en_d, mem_we_d, busy_d, cmd_err_d;
   logic                   accept;
   logic [1:0]             cmd;
   logic [ADDR_SIZE-1:0]   payload;
   logic                   in_range;

   spi_cmd_decode #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_decode (
      .rx_data  (rx_data),
      .cmd      (cmd),
      .payload  (payload),
      .in_range (in_range)
   );

   function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   // Next-state, address registers and RAM strobes for the command in hand.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      wr_addr_d     = wr_addr_q;
      rd_addr_d     = rd_addr_q;
      wr_addr_vld_d = wr_addr_vld_q;
      rd_addr_vld_d = rd_addr_vld_q;
      tx_data_d     = tx_data;
      tx_valid_d    = tx_valid;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      mem_en_d      = 1'b0;
      mem_we_d      = 1'b0;
      cmd_err_d     = 1'b0;
      accept        = 1'b0;

      case (state_q)
         IDLE: accept = rx_valid;
         RD_WAIT: begin
            if (cnt_q == LAT_L) begin
               tx_data_d  = mem_rdata;
               tx_valid_d = 1'b1;
               state_d    = TX_HOLD;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
            if (rx_valid) begin
               cmd_err_d = 1'b1;
            end
         end
         TX_HOLD: begin
            if (rx_valid) begin
               tx_valid_d = 1'b0;
               state_d    = IDLE;
               accept     = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         case (cmd)
            CMD_WR_ADDR: begin
               if (in_range) begin
                  wr_addr_d     = payload;
                  wr_addr_vld_d = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            CMD_WR_DATA: begin
               if (wr_addr_vld_q) begin
                  mem_en_d    = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = wr_addr_q;
                  mem_wdata_d = payload;
                  if (AUTO_INC != 0) begin
                     wr_addr_d = next_addr(wr_addr_q);
                  end
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            CMD_RD_ADDR: begin
               if (in_range) begin
                  rd_addr_d     = payload;
                  rd_addr_vld_d = 1'b1;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
            default: begin
               if (rd_addr_vld_q) begin
                  mem_en_d   = 1'b1;
                  mem_addr_d = rd_addr_q;
                  cnt_d      = 2'd0;
                  state_d    = RD_WAIT;
                  if (AUTO_INC != 0) begin
                     rd_addr_d = next_addr(rd_addr_q);
                  end
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         endcase
      end

      busy_d = (state_d == RD_WAIT);
   end

   // State and output registers; reset abandons any read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         wr_addr_vld_q <= 1'b0;
         rd_addr_vld_q <= 1'b0;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         busy          <= 1'b0;
         cmd_err       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         wr_addr_vld_q <= wr_addr_vld_d;
         rd_addr_vld_q <= rd_addr_vld_d;
         tx_data       <= tx_data_d;
         tx_valid      <= tx_valid_d;
         mem_en        <= mem_en_d;
         mem_we        <= mem_we_d;
         mem_addr      <= mem_addr_d;
         mem_wdata     <= mem_wdata_d;
         busy          <= busy_d;
         cmd_err       <= cmd_err_d;
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: three instances with different
// depth / latency / auto-increment settings, each with a behavioural RAM.
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] rx_data  [3];
   logic       rx_valid [3];
   logic [7:0] tx_data  [3];
   logic       tx_valid [3];
   logic       mem_en   [3];
   logic       mem_we   [3];
   logic [7:0] mem_addr [3];
   logic [7:0] mem_wdata[3];
   logic [7:0] mem_rdata[3];
   logic       busy     [3];
   logic       cmd_err  [3];

   logic [7:0] ram  [3][256];
   logic [7:0] pipe [3][3];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         dut;
      logic [9:0] word;
      logic       en;
      logic       we;
      logic       err;
      logic       tx;
      logic [7:0] addr;
      logic [7:0] wdata;
   } vec_t;

   vec_t vecs[13];

   always #5 clk = ~clk;

   // dut 0: defaults (depth 256, latency 1, no auto-increment)
   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LAT(1), .AUTO_INC(0)) dut0 (
      .clk(clk), .rst(rst), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
      .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .mem_en(mem_en[0]),
      .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]), .cmd_err(cmd_err[0]));

   // dut 1: depth 200, latency 3
   spi_ram_ctrl #(.MEM_DEPTH(200), .ADDR_SIZE(8), .RD_LAT(3), .AUTO_INC(0)) dut1 (
      .clk(clk), .rst(rst), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
      .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .mem_en(mem_en[1]),
      .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]), .cmd_err(cmd_err[1]));

   // dut 2: depth 256, latency 2, auto-increment
   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LAT(2), .AUTO_INC(1)) dut2 (
      .clk(clk), .rst(rst), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
      .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .mem_en(mem_en[2]),
      .mem_we(mem_we[2]), .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]),
      .mem_rdata(mem_rdata[2]), .busy(busy[2]), .cmd_err(cmd_err[2]));

   assign mem_rdata[0] = pipe[0][0];
   assign mem_rdata[1] = pipe[1][2];
   assign mem_rdata[2] = pipe[2][1];

   // Behavioural synchronous RAMs with a read pipeline per instance.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (mem_en[i] && mem_we[i]) ram[i][mem_addr[i]] <= mem_wdata[i];
         if (mem_en[i] && !mem_we[i]) pipe[i][0] <= ram[i][mem_addr[i]];
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One-cycle rx_valid strobe; returns at the negedge after the sampling edge.
   task automatic applyStimulus(input int idx, input logic [9:0] word);
      @(negedge clk);
      rx_data[idx]  = word;
      rx_valid[idx] = 1'b1;
      @(negedge clk);
      rx_valid[idx] = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{0, {2'b01, 8'h33}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[1]  = '{0, {2'b11, 8'h00}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[2]  = '{0, {2'b00, 8'h12}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[3]  = '{0, {2'b01, 8'hA5}, 1'b1, 1'b1, 1'b0, 1'b0, 8'h12, 8'hA5};
      vecs[4]  = '{1, {2'b00, 8'hC8}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[5]  = '{1, {2'b01, 8'h01}, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
      vecs[6]  = '{1, {2'b00, 8'hC7}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[7]  = '{1, {2'b01, 8'h01}, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC7, 8'h01};
      vecs[8]  = '{2, {2'b00, 8'hFF}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[9]  = '{2, {2'b01, 8'h11}, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h11};
      vecs[10] = '{2, {2'b01, 8'h22}, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h22};
      vecs[11] = '{2, {2'b10, 8'hFE}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[12] = '{0, {2'b10, 8'h12}, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};

      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rx_data[i]  = '0;
         rx_valid[i] = 1'b0;
      end
      waitCycles(3);
      rst = 1'b0;

      for (int i = 0; i < 3; i++) begin
         checkOutput("reset tx_valid", 32'(tx_valid[i]), 32'h0);
         checkOutput("reset mem_en",   32'(mem_en[i]),   32'h0);
         checkOutput("reset busy",     32'(busy[i]),     32'h0);
         checkOutput("reset cmd_err",  32'(cmd_err[i]),  32'h0);
         checkOutput("reset mem_addr", 32'(mem_addr[i]), 32'h0);
      end

      for (int v = 0; v < 13; v++) begin
         applyStimulus(vecs[v].dut, vecs[v].word);
         checkOutput($sformatf("vec%0d mem_en", v),   32'(mem_en[vecs[v].dut]),   32'(vecs[v].en));
         checkOutput($sformatf("vec%0d mem_we", v),   32'(mem_we[vecs[v].dut]),   32'(vecs[v].we));
         checkOutput($sformatf("vec%0d cmd_err", v),  32'(cmd_err[vecs[v].dut]),  32'(vecs[v].err));
         checkOutput($sformatf("vec%0d tx_valid", v), 32'(tx_valid[vecs[v].dut]), 32'(vecs[v].tx));
         if (vecs[v].en) begin
            checkOutput($sformatf("vec%0d mem_addr", v),  32'(mem_addr[vecs[v].dut]),  32'(vecs[v].addr));
            checkOutput($sformatf("vec%0d mem_wdata", v), 32'(mem_wdata[vecs[v].dut]), 32'(vecs[v].wdata));
         end
         waitCycles(1);
         checkOutput($sformatf("vec%0d en pulse", v),  32'(mem_en[vecs[v].dut]),  32'h0);
         checkOutput($sformatf("vec%0d err pulse", v), 32'(cmd_err[vecs[v].dut]), 32'h0);
      end

      // Read back 0x12 on dut0, latency 1
      applyStimulus(0, {2'b11, 8'h00});
      checkOutput("rd0 mem_en",   32'(mem_en[0]),   32'h1);
      checkOutput("rd0 mem_we",   32'(mem_we[0]),   32'h0);
      checkOutput("rd0 mem_addr", 32'(mem_addr[0]), 32'h12);
      checkOutput("rd0 busy",     32'(busy[0]),     32'h1);
      waitCycles(1);
      checkOutput("rd0 early tx", 32'(tx_valid[0]), 32'h0);
      waitCycles(1);
      checkOutput("rd0 tx_valid", 32'(tx_valid[0]), 32'h1);
      checkOutput("rd0 tx_data",  32'(tx_data[0]),  32'hA5);
      checkOutput("rd0 busy off", 32'(busy[0]),     32'h0);
      waitCycles(3);
      checkOutput("rd0 hold valid", 32'(tx_valid[0]), 32'h1);
      checkOutput("rd0 hold data",  32'(tx_data[0]),  32'hA5);

      // Back-to-back read with a command colliding on the final wait cycle
      applyStimulus(0, {2'b11, 8'h00});
      checkOutput("b2b tx cleared", 32'(tx_valid[0]), 32'h0);
      checkOutput("b2b mem_en",     32'(mem_en[0]),   32'h1);
      waitCycles(1);
      rx_data[0]  = {2'b00, 8'h40};
      rx_valid[0] = 1'b1;
      waitCycles(1);
      rx_valid[0] = 1'b0;
      checkOutput("collide tx_valid", 32'(tx_valid[0]), 32'h1);
      checkOutput("collide tx_data",  32'(tx_data[0]),  32'hA5);
      checkOutput("collide cmd_err",  32'(cmd_err[0]),  32'h1);
      applyStimulus(0, {2'b01, 8'h77});
      checkOutput("collide wr addr",  32'(mem_addr[0]),  32'h12);
      checkOutput("collide wr data",  32'(mem_wdata[0]), 32'h77);
      checkOutput("collide tx clr",   32'(tx_valid[0]),  32'h0);

      // dut1 latency 3, command arriving mid-read
      applyStimulus(1, {2'b10, 8'hC7});
      applyStimulus(1, {2'b11, 8'h00});
      checkOutput("lat3 mem_addr", 32'(mem_addr[1]), 32'hC7);
      waitCycles(1);
      checkOutput("lat3 tx e1", 32'(tx_valid[1]), 32'h0);
      rx_data[1]  = {2'b00, 8'h05};
      rx_valid[1] = 1'b1;
      waitCycles(1);
      rx_valid[1] = 1'b0;
      checkOutput("lat3 cmd_err", 32'(cmd_err[1]),  32'h1);
      checkOutput("lat3 busy",    32'(busy[1]),     32'h1);
      checkOutput("lat3 tx e2",   32'(tx_valid[1]), 32'h0);
      waitCycles(1);
      checkOutput("lat3 tx e3",   32'(tx_valid[1]), 32'h0);
      waitCycles(1);
      checkOutput("lat3 tx_valid", 32'(tx_valid[1]), 32'h1);
      checkOutput("lat3 tx_data",  32'(tx_data[1]),  32'h01);
      applyStimulus(1, {2'b01, 8'h09});
      checkOutput("lat3 wr_addr kept", 32'(mem_addr[1]), 32'hC7);

      // dut2 auto-increment reads wrap FE, FF, 00
      applyStimulus(2, {2'b11, 8'h00});
      checkOutput("inc rd0 addr", 32'(mem_addr[2]), 32'hFE);
      waitCycles(2);
      checkOutput("inc lat2 early", 32'(tx_valid[2]), 32'h0);
      waitCycles(1);
      checkOutput("inc lat2 valid", 32'(tx_valid[2]), 32'h1);
      applyStimulus(2, {2'b11, 8'h00});
      checkOutput("inc rd1 addr", 32'(mem_addr[2]), 32'hFF);
      waitCycles(3);
      checkOutput("inc rd1 data", 32'(tx_data[2]), 32'h11);
      applyStimulus(2, {2'b11, 8'h00});
      checkOutput("inc rd2 addr", 32'(mem_addr[2]), 32'h00);
      waitCycles(3);
      checkOutput("inc rd2 data", 32'(tx_data[2]), 32'h22);

      // Reset during RD_WAIT on dut1
      applyStimulus(1, {2'b11, 8'h00});
      checkOutput("rst pre mem_en", 32'(mem_en[1]), 32'h1);
      rst = 1'b1;
      waitCycles(1);
      rst = 1'b0;
      checkOutput("rst mem_en",    32'(mem_en[1]),    32'h0);
      checkOutput("rst mem_we",    32'(mem_we[1]),    32'h0);
      checkOutput("rst mem_addr",  32'(mem_addr[1]),  32'h0);
      checkOutput("rst mem_wdata", 32'(mem_wdata[1]), 32'h0);
      checkOutput("rst tx_valid",  32'(tx_valid[1]),  32'h0);
      checkOutput("rst tx_data",   32'(tx_data[1]),   32'h0);
      checkOutput("rst busy",      32'(busy[1]),      32'h0);
      checkOutput("rst cmd_err",   32'(cmd_err[1]),   32'h0);
      for (int c = 0; c < 5; c++) begin
         waitCycles(1);
         checkOutput("rst no tx", 32'(tx_valid[1]), 32'h0);
      end
      applyStimulus(1, {2'b11, 8'h00});
      checkOutput("rst rd cmd_err", 32'(cmd_err[1]), 32'h1);
      checkOutput("rst rd mem_en",  32'(mem_en[1]),  32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
